// File: rtl/par2ser_pkg.sv
// ---------------------------------------------------------------------------
// par2ser_pkg
// Shared definitions for the parallel-to-serial feeder:
//   state_e        - FSM state encoding (IDLE / SHIFT)
//   cnt_width()    - bit counter width for a given word width
//   first_bit_idx()- shifter bit that is presented first on ser_out
// ---------------------------------------------------------------------------
package par2ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter only has to reach width-1, so clog2(width) bits suffice.
  // Width is always >= 2, the floor of 1 just keeps the function total.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // The shifter always moves bits toward this position, so ser_out is a
  // fixed tap regardless of how far into the word we are.
  function automatic int first_bit_idx(input int width, input bit msb_first);
    return msb_first ? (width - 1) : 0;
  endfunction

endpackage

// File: rtl/par2ser_hold_buf.sv
// ---------------------------------------------------------------------------
// par2ser_hold_buf
// One-entry holding register with a full flag, sitting between the
// valid/ready source and the shifter.
//   clk, rst  - clock, asynchronous active-low reset
//   wr_en     - store wr_data and set full (source handshake completed)
//   wr_data   - word from the source
//   rd_en     - shifter took the word; clear full
//   full      - an unread word is held
//   data      - the held word
// The parent never asserts wr_en and rd_en together: a write needs the
// buffer empty and a read needs it full.
// ---------------------------------------------------------------------------
module par2ser_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (rd_en) begin
      full_d = 1'b0;
    end
    if (wr_en) begin
      full_d = 1'b1;
      data_d = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/par2ser_feeder.sv
// ---------------------------------------------------------------------------
// par2ser_feeder
// Accepts parallel words over valid/ready and streams them out one bit per
// enabled clock, feeding the serial sequence detector.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   din        - parallel word from the source
//   din_valid  - source presents a word on din
//   din_ready  - block can take a word this cycle
//   ser_en     - downstream advance enable; 0 freezes the serial output
//   ser_out    - current serial bit
//   ser_valid  - ser_out carries a data bit
//   word_last  - high with the final bit of each word
//   busy       - ser_valid or holding buffer full
//   dbg_state  - current FSM state, for observation only
//
// Handshake: a word transfers at a rising edge where din_valid & din_ready.
// din_ready depends only on rst and the buffer full flag, never on
// din_valid or ser_en; while it is low the source holds din/din_valid.
// A serial bit is consumed at a rising edge where ser_valid & ser_en.
// ---------------------------------------------------------------------------
module par2ser_feeder
  import par2ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_last,
  output logic             busy,
  output state_e           dbg_state
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam int              FIRST    = first_bit_idx(WIDTH, MSB_FIRST);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               ser_out_q, ser_out_d;
  logic               word_last_q, word_last_d;

  logic               hold_full;
  logic [WIDTH-1:0]   hold_data;
  logic               accept;
  logic               load;
  logic               consume;
  logic               last_consume;

  assign din_ready = rst & ~hold_full;
  assign accept    = din_valid & din_ready;

  par2ser_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (din),
    .rd_en   (load),
    .full    (hold_full),
    .data    (hold_data)
  );

  // Next-state, shifter and counter.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    consume      = (state_q == ST_SHIFT) & ser_en;
    last_consume = consume & (cnt_q == LAST_CNT);
    load         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Loading from idle does not wait for ser_en: it only makes the
        // first bit visible, nothing is consumed.
        if (hold_full) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = hold_data;
        end
      end
      ST_SHIFT: begin
        if (last_consume) begin
          if (hold_full) begin
            // Chain straight into the buffered word, no bubble.
            load    = 1'b1;
            cnt_d   = '0;
            shreg_d = hold_data;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end else if (consume) begin
          cnt_d   = cnt_q + CNT_W'(1);
          shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, shreg_q[WIDTH-1:1]};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase

    // Outputs are registered from the next state so they change only on a
    // clock edge (or reset) and are forced to 0 outside SHIFT.
    ser_out_d   = (state_d == ST_SHIFT) & shreg_d[FIRST];
    word_last_d = (state_d == ST_SHIFT) & (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ser_out_q   <= 1'b0;
      word_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      word_last_q <= word_last_d;
    end
  end

  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_out   = ser_out_q;
  assign word_last = word_last_q;
  assign busy      = ser_valid | hold_full;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_par2ser_feeder.sv
// ---------------------------------------------------------------------------
// tb_par2ser_feeder
// Two instances share clock, reset and the source/enable inputs: index 0 is
// MSB-first, index 1 is LSB-first. Each accepted word pushes its expected
// bit stream ({last, bit} per bit) onto a per-instance queue; a monitor on
// the falling edge pops one entry for every consumed bit and compares.
// ---------------------------------------------------------------------------
module tb_par2ser_feeder;
  import par2ser_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         ser_en = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] dr, so, sv, wl, bz;
  state_e     st_m, st_l;

  par2ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(dr[0]), .ser_en(ser_en), .ser_out(so[0]),
    .ser_valid(sv[0]), .word_last(wl[0]), .busy(bz[0]), .dbg_state(st_m)
  );

  par2ser_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(dr[1]), .ser_en(ser_en), .ser_out(so[1]),
    .ser_valid(sv[1]), .word_last(wl[1]), .busy(bz[1]), .dbg_state(st_l)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_m[$];
  logic [1:0] exp_l[$];
  int         en_mode = 0;   // 0: always on, 1: toggle, 2: random
  int         run_len = 0;
  int         max_run = 0;
  logic [1:0] prev_hold = '0;
  logic [1:0] prev_so = '0;
  logic [1:0] prev_wl = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bit i of the stream is din[W-1-i] (MSB first) or
  // din[i] (LSB first); the W-th bit carries the last flag.
  task automatic push_word(input logic [W-1:0] w);
    logic lb;
    for (int i = 0; i < W; i++) begin
      lb = (i == W - 1);
      exp_m.push_back({lb, w[W-1-i]});
      exp_l.push_back({lb, w[i]});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      prev_hold = '0;
      run_len   = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (prev_hold[d]) begin
          check(d == 0 ? "m_hold_valid" : "l_hold_valid", sv[d], 1);
          check(d == 0 ? "m_hold_bit"   : "l_hold_bit",   so[d], prev_so[d]);
          check(d == 0 ? "m_hold_last"  : "l_hold_last",  wl[d], prev_wl[d]);
        end
        if (!sv[d]) begin
          check(d == 0 ? "m_idle_out"  : "l_idle_out",  so[d], 0);
          check(d == 0 ? "m_idle_last" : "l_idle_last", wl[d], 0);
        end else if (ser_en) begin
          if ((d == 0 ? exp_m.size() : exp_l.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_bit dut%0d: valid bit with no expected bit (t=%0t)", d, $time);
          end else begin
            e = (d == 0) ? exp_m.pop_front() : exp_l.pop_front();
            check(d == 0 ? "m_bit"  : "l_bit",  so[d], e[0]);
            check(d == 0 ? "m_last" : "l_last", wl[d], e[1]);
          end
        end
        prev_hold[d] = sv[d] & ~ser_en;
        prev_so[d]   = so[d];
        prev_wl[d]   = wl[d];
      end
      if (sv[0]) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0:       ser_en = 1'b1;
        1:       ser_en = ~ser_en;
        default: ser_en = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic drive_word(input logic [W-1:0] w);
    int waited;
    waited    = 0;
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    while (dr[0] !== 1'b1 && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check("accept_in_time", (waited < 200), 1);
    if (waited < 200) push_word(w);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_m.size() == 0 && exp_l.size() == 0 && sv == 2'b00 && bz == 2'b00) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", (n < 1000), 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gap;
    int n;

    // Reset with inputs active: everything must stay at 0.
    din       = 8'hFF;
    din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_out",   so, 0);
    check("rst_ser_valid", sv, 0);
    check("rst_word_last", wl, 0);
    check("rst_busy",      bz, 0);
    check("rst_din_ready", dr, 0);
    din_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("post_rst_ready", dr, 2'b11);
    check("post_rst_busy",  bz, 0);
    @(posedge clk);
    #1;

    // Single word: latency and end-of-word.
    drive_word(8'hD0);
    check("lat_not_yet_valid", sv, 0);
    check("lat_busy",          bz, 2'b11);
    check("lat_ready_low",     dr, 0);
    @(posedge clk);
    #1;
    check("lat_first_valid", sv, 2'b11);
    check("lat_first_bit",   so[0], 1);
    repeat (8) @(posedge clk);
    #1;
    check("cycle9_valid", sv, 0);
    check("cycle9_last",  wl, 0);
    wait_idle();

    // Back-to-back stream of three words, din_valid held high.
    max_run = 0;
    drive_word(8'hD0);
    drive_word(8'h0D);
    check("full_ready_low", dr, 0);
    check("full_busy",      bz, 2'b11);
    drive_word(8'hAA);
    wait_idle();
    check("contiguous_bits", max_run, 24);

    // ser_en toggling every cycle.
    en_mode = 1;
    drive_word(8'hD0);
    wait_idle();
    en_mode = 0;
    @(posedge clk);
    #1;

    // Accept on the same edge that consumes the last bit: one bubble.
    drive_word(8'h5C);
    n = 0;
    while (wl[0] !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("saw_word_last", (n < 50), 1);
    drive_word(8'h81);
    check("bubble_valid", sv, 0);
    check("bubble_busy",  bz, 2'b11);
    @(posedge clk);
    #1;
    check("after_bubble_valid", sv, 2'b11);
    wait_idle();

    // Reset mid-word: outputs clear without a clock edge.
    drive_word(8'hD0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ser_out",   so, 0);
    check("midrst_ser_valid", sv, 0);
    check("midrst_word_last", wl, 0);
    check("midrst_busy",      bz, 0);
    check("midrst_ready",     dr, 0);
    exp_m.delete();
    exp_l.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive_word(8'hB0);
    wait_idle();

    // LSB-first directed word (MSB-first instance sees it too).
    drive_word(8'h0B);
    wait_idle();

    // Random words, random gaps, random ser_en.
    en_mode = 2;
    for (int k = 0; k < 40; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      drive_word(W'($urandom));
    end
    wait_idle();
    en_mode = 0;

    check("final_queue_m", exp_m.size(), 0);
    check("final_queue_l", exp_l.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
